// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    // Requester indices into the two-bit request/grant vectors.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant logic for the fetch and data ports.
// ARB_DATA_PRIORITY_EN selects fixed data-port priority instead of round-robin.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef ARB_DATA_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 2'b00;
        if (req[PORT_D]) begin
            grant[PORT_D] = 1'b1;
        end else if (req[PORT_IF]) begin
            grant[PORT_IF] = 1'b1;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (&req) begin
            // On a tie the port that was not served last time wins.
            grant[~last_grant] = 1'b1;
        end else begin
            grant = req;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch (IF) and load/store (D) ports.
// Define ARB_DATA_PRIORITY_EN for fixed D-over-IF priority; round-robin otherwise.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            err,
    output logic            busy
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_e    state_q;
    logic          last_grant_q;
    logic          owner_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    grant;
    logic          timed_out;

    arb_rr2 u_arb (
        .req        ({d_req, if_req}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // The counter sits on CNT_LAST during the final permitted ISSUE cycle.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            owner_q      <= PORT_IF;
            cnt_q        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
            err          <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        state_q      <= ISSUE;
                        mem_req      <= 1'b1;
                        cnt_q        <= '0;
                        last_grant_q <= grant[PORT_D];
                        owner_q      <= grant[PORT_D];
                        if (grant[PORT_D]) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack || timed_out) begin
                        state_q <= RESP;
                        mem_req <= 1'b0;
                        // A real ack takes precedence over a coincident timeout.
                        err     <= !mem_ack;
                        if (owner_q == PORT_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    if_ack   <= 1'b0;
                    d_ack    <= 1'b0;
                    err      <= 1'b0;
                    if_rdata <= '0;
                    d_rdata  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
